// File: rtl/fft_frame_loader_if.sv
// Sample-in / frame-word-out bus of the FFT frame loader.
// The loader attaches through the master modport; the bench or upstream logic uses slave.
interface fft_frame_loader_if #(
    parameter int DATLEN = 12,
    parameter int LOG2N  = 4
);
    logic [DATLEN-1:0]   s_data;
    logic                s_valid;
    logic [2*DATLEN-1:0] o_data;
    logic                o_valid;
    logic                o_ready;
    logic                o_last;
    logic [LOG2N-1:0]    o_index;
    logic [15:0]         drop_count;

    modport master (
        input  s_data, s_valid, o_ready,
        output o_data, o_valid, o_last, o_index, drop_count
    );

    modport slave (
        output s_data, s_valid, o_ready,
        input  o_data, o_valid, o_last, o_index, drop_count
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader: fills N-sample banks from the ADC and streams complete
// frames to the FFT as {imag=0, real=sample}, optionally in bit-reversed order.
//
// state     | meaning
// WR_FILL   | writing samples into bank wr_bank at wr_idx
// WR_WAIT   | both banks full; incoming samples are dropped and counted
// RD_IDLE   | waiting for bank rd_bank to become full
// RD_STREAM | presenting word rd_idx of bank rd_bank until the FFT takes it
module fft_frame_loader #(
    parameter int DATLEN = 12,
    parameter int LOG2N  = 4,
    parameter int BITREV = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    fft_frame_loader_if.master bus
);
    localparam int N = 1 << LOG2N;

    typedef enum logic {WR_FILL, WR_WAIT}   wr_state_t;
    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

    wr_state_t wr_state, wr_state_nx;
    rd_state_t rd_state, rd_state_nx;

    logic [DATLEN-1:0] mem [2*N];

    logic [LOG2N-1:0] wr_idx, wr_idx_nx;
    logic [LOG2N-1:0] rd_idx, rd_idx_nx;
    logic [LOG2N-1:0] rd_addr;
    logic             wr_bank, wr_bank_nx;
    logic             rd_bank, rd_bank_nx;
    logic [1:0]       full, full_nx;
    logic             mem_we;
    logic [LOG2N:0]   mem_waddr;
    logic             drop;
    logic [15:0]      drop_count;
    logic             xfer;
    logic             release_rd;
    logic             other_free;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    assign rd_addr    = (BITREV != 0) ? bitrev(rd_idx) : rd_idx;
    assign xfer       = (rd_state == RD_STREAM) && bus.o_ready;
    assign release_rd = xfer && (rd_idx == '1);
    // A bank being released this very cycle already counts as free for the writer.
    assign other_free = !full[!wr_bank] || (release_rd && (rd_bank != wr_bank));

    always_comb begin
        rd_state_nx = rd_state;
        rd_idx_nx   = rd_idx;
        rd_bank_nx  = rd_bank;
        case (rd_state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    rd_idx_nx   = '0;
                    rd_state_nx = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (xfer) begin
                    rd_idx_nx = rd_idx + 1'b1;
                    if (rd_idx == '1) begin
                        rd_bank_nx  = !rd_bank;
                        rd_state_nx = RD_IDLE;
                    end
                end
            end
            default: rd_state_nx = RD_IDLE;
        endcase
    end

    always_comb begin
        wr_state_nx = wr_state;
        wr_idx_nx   = wr_idx;
        wr_bank_nx  = wr_bank;
        mem_we      = 1'b0;
        mem_waddr   = {wr_bank, wr_idx};
        drop        = 1'b0;
        full_nx     = full;
        if (release_rd) full_nx[rd_bank] = 1'b0;
        case (wr_state)
            WR_FILL: begin
                if (bus.s_valid) begin
                    mem_we    = 1'b1;
                    wr_idx_nx = wr_idx + 1'b1;
                    if (wr_idx == '1) begin
                        full_nx[wr_bank] = 1'b1;
                        if (other_free) wr_bank_nx  = !wr_bank;
                        else            wr_state_nx = WR_WAIT;
                    end
                end
            end
            WR_WAIT: begin
                if (other_free) begin
                    wr_bank_nx  = !wr_bank;
                    wr_state_nx = WR_FILL;
                    if (bus.s_valid) begin
                        mem_we    = 1'b1;
                        mem_waddr = {!wr_bank, {LOG2N{1'b0}}};
                        wr_idx_nx = LOG2N'(1);
                    end
                end else if (bus.s_valid) begin
                    drop = 1'b1;
                end
            end
            default: wr_state_nx = WR_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state   <= WR_FILL;
            rd_state   <= RD_IDLE;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            full       <= '0;
            drop_count <= '0;
        end else begin
            wr_state <= wr_state_nx;
            rd_state <= rd_state_nx;
            wr_bank  <= wr_bank_nx;
            rd_bank  <= rd_bank_nx;
            wr_idx   <= wr_idx_nx;
            rd_idx   <= rd_idx_nx;
            full     <= full_nx;
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= bus.s_data;
    end

    // Outputs are gated by the reader state so reset clears them without touching the banks.
    assign bus.o_valid    = (rd_state == RD_STREAM);
    assign bus.o_data     = bus.o_valid ? {{DATLEN{1'b0}}, mem[{rd_bank, rd_addr}]} : '0;
    assign bus.o_index    = bus.o_valid ? rd_addr : '0;
    assign bus.o_last     = bus.o_valid && (rd_idx == '1);
    assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: directed and random frames against a frame-level
// reference model, on 16-point (bit-reversed and natural) and 32-point/14-bit instances.
module tb_fft_frame_loader;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fft_frame_loader_if #(.DATLEN(12), .LOG2N(4)) ifa ();
    fft_frame_loader_if #(.DATLEN(12), .LOG2N(4)) ifb ();
    fft_frame_loader_if #(.DATLEN(14), .LOG2N(5)) ifc ();

    fft_frame_loader #(.DATLEN(12), .LOG2N(4), .BITREV(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    fft_frame_loader #(.DATLEN(12), .LOG2N(4), .BITREV(0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
    fft_frame_loader #(.DATLEN(14), .LOG2N(5), .BITREV(1)) dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    int qa_d[$], qa_i[$], qa_l[$], qa_c[$];
    int qb_d[$], qb_i[$], qb_l[$];
    int qc_d[$], qc_i[$], qc_l[$];
    int e_d[$], e_i[$], e_l[$];
    int fr[$];

    int          a_unstable = 0;
    logic        a_stall = 1'b0;
    logic [23:0] a_pd = '0;
    logic [3:0]  a_pi = '0;
    logic        a_pl = 1'b0;

    always @(negedge clk) begin
        if (ifa.o_valid && ifa.o_ready) begin
            qa_d.push_back(int'(ifa.o_data)); qa_i.push_back(int'(ifa.o_index));
            qa_l.push_back(int'(ifa.o_last)); qa_c.push_back(cyc);
        end
        if (ifb.o_valid && ifb.o_ready) begin
            qb_d.push_back(int'(ifb.o_data)); qb_i.push_back(int'(ifb.o_index)); qb_l.push_back(int'(ifb.o_last));
        end
        if (ifc.o_valid && ifc.o_ready) begin
            qc_d.push_back(int'(ifc.o_data)); qc_i.push_back(int'(ifc.o_index)); qc_l.push_back(int'(ifc.o_last));
        end
        if (reset_n && a_stall &&
            (ifa.o_valid !== 1'b1 || ifa.o_data !== a_pd || ifa.o_index !== a_pi || ifa.o_last !== a_pl))
            a_unstable++;
        a_stall = reset_n && ifa.o_valid && !ifa.o_ready;
        a_pd = ifa.o_data; a_pi = ifa.o_index; a_pl = ifa.o_last;
    end

    function automatic int brev(input int k, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    // Reference: a completed frame leaves as N words; word j carries sample brev(j) (or j).
    task automatic expect_frame(input int log2n, input bit bitrev_order);
        int n = 1 << log2n;
        for (int j = 0; j < n; j++) begin
            int a = bitrev_order ? brev(j, log2n) : j;
            e_d.push_back(fr[a]); e_i.push_back(a); e_l.push_back(j == n - 1 ? 1 : 0);
        end
        for (int j = 0; j < n; j++) void'(fr.pop_front());
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cmp(input string tag, input int sel);
        int d[$], ix[$], l[$];
        case (sel)
            0: begin d = qa_d; ix = qa_i; l = qa_l; qa_d.delete(); qa_i.delete(); qa_l.delete(); qa_c.delete(); end
            1: begin d = qb_d; ix = qb_i; l = qb_l; qb_d.delete(); qb_i.delete(); qb_l.delete(); end
            default: begin d = qc_d; ix = qc_i; l = qc_l; qc_d.delete(); qc_i.delete(); qc_l.delete(); end
        endcase
        check({tag, " word_count"}, 32'(d.size()), 32'(e_d.size()));
        for (int i = 0; i < d.size() && i < e_d.size(); i++) begin
            check($sformatf("%s w%0d data", tag, i), d[i], e_d[i]);
            check($sformatf("%s w%0d index", tag, i), ix[i], e_i[i]);
            check($sformatf("%s w%0d last", tag, i), l[i], e_l[i]);
        end
        e_d.delete(); e_i.delete(); e_l.delete();
    endtask

    task automatic wait_drain(input int sel, input int want, input int budget);
        int n;
        for (int c = 0; c < budget; c++) begin
            n = (sel == 0) ? qa_d.size() : (sel == 1) ? qb_d.size() : qc_d.size();
            if (n >= want) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic step(input bit va, input int da, input bit ra);
        @(posedge clk);
        #1;
        ifa.s_valid = va; ifa.s_data = 12'(da); ifa.o_ready = ra;
    endtask

    initial begin
        int v, fed, first_x;
        bit r;
        ifa.s_valid = 0; ifa.s_data = '0; ifa.o_ready = 1;
        ifb.s_valid = 0; ifb.s_data = '0; ifb.o_ready = 1;
        ifc.s_valid = 0; ifc.s_data = '0; ifc.o_ready = 1;

        repeat (3) @(posedge clk);
        #1;
        check("reset o_valid", 32'(ifa.o_valid), 0);
        check("reset o_data", 32'(ifa.o_data), 0);
        check("reset o_index", 32'(ifa.o_index), 0);
        check("reset o_last", 32'(ifa.o_last), 0);
        check("reset drop_count", 32'(ifa.drop_count), 0);
        reset_n = 1;

        // Ramp 0..15 into the bit-reversed and natural-order instances together
        for (int k = 0; k < 16; k++) begin
            step(1, k, 1);
            ifb.s_valid = 1; ifb.s_data = 12'(k);
        end
        step(0, 0, 1);
        ifb.s_valid = 0;
        check("ramp o_valid at last write", 32'(ifa.o_valid), 0);
        step(0, 0, 1);
        check("ramp o_valid two cycles on", 32'(ifa.o_valid), 1);
        wait_drain(0, 16, 60);
        check("ramp drain consecutive", (qa_c.size() == 16) ? 32'(qa_c[15] - qa_c[0]) : 32'hFFFF_FFFF, 15);
        for (int k = 0; k < 16; k++) fr.push_back(k);
        expect_frame(4, 1);
        cmp("ramp_bitrev", 0);
        for (int k = 0; k < 16; k++) fr.push_back(k);
        expect_frame(4, 0);
        cmp("ramp_natural", 1);

        // 32-point, 14-bit instance
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            ifc.s_valid = 1; ifc.s_data = 14'(16'h3FFF - k);
            fr.push_back(16'h3FFF - k);
        end
        @(posedge clk); #1;
        ifc.s_valid = 0;
        wait_drain(2, 32, 80);
        expect_frame(5, 1);
        cmp("n32", 2);

        // Stalled FFT: third frame has no free bank
        step(0, 0, 0);
        for (int f = 1; f <= 3; f++)
            for (int k = 0; k < 16; k++) step(1, f * 256 + k, 0);
        step(0, 0, 0);
        repeat (3) step(0, 0, 0);
        check("stall drop_count", 32'(ifa.drop_count), 16);
        check("stall o_valid", 32'(ifa.o_valid), 1);
        check("stall o_data held", 32'(ifa.o_data), 32'h100);
        for (int f = 1; f <= 2; f++) begin
            for (int k = 0; k < 16; k++) fr.push_back(f * 256 + k);
            expect_frame(4, 1);
        end
        step(0, 0, 1);
        wait_drain(0, 32, 100);
        cmp("stall_release", 0);
        check("stall drop_count after", 32'(ifa.drop_count), 16);

        // o_ready toggling every cycle
        r = 1;
        for (int k = 0; k < 16; k++) begin
            v = int'($urandom_range(0, 4095));
            fr.push_back(v);
            step(1, v, r);
            r = !r;
        end
        expect_frame(4, 1);
        for (int c = 0; c < 80 && qa_d.size() < 16; c++) begin
            step(0, 0, r);
            r = !r;
        end
        step(0, 0, 1);
        wait_drain(0, 16, 10);
        cmp("toggle", 0);
        check("toggle stable while stalled", 32'(a_unstable), 0);

        // Gappy random samples, FFT always ready: lossless
        fed = 0;
        while (fed < 48) begin
            if ($urandom_range(0, 1) == 1) begin
                v = int'($urandom_range(0, 4095));
                fr.push_back(v);
                step(1, v, 1);
                fed++;
            end else begin
                step(0, 0, 1);
            end
        end
        step(0, 0, 1);
        for (int f = 0; f < 3; f++) expect_frame(4, 1);
        wait_drain(0, 48, 200);
        cmp("gappy", 0);
        check("gappy drop_count", 32'(ifa.drop_count), 16);

        // Asynchronous reset mid-frame while a frame is being presented
        first_x = int'($urandom_range(1, 4095));
        step(1, first_x, 0);
        for (int k = 1; k < 16; k++) step(1, int'($urandom_range(0, 4095)), 0);
        for (int k = 0; k < 8; k++) step(1, k + 7, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("pre_reset o_valid", 32'(ifa.o_valid), 1);
        check("pre_reset o_data", 32'(ifa.o_data), 32'(first_x));
        #2;
        reset_n = 0;
        #1;
        check("async reset o_valid", 32'(ifa.o_valid), 0);
        check("async reset o_data", 32'(ifa.o_data), 0);
        check("async reset drop_count", 32'(ifa.drop_count), 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        ifa.o_ready = 1;
        qa_d.delete(); qa_i.delete(); qa_l.delete(); qa_c.delete();
        for (int k = 0; k < 16; k++) begin
            v = int'($urandom_range(0, 4095));
            fr.push_back(v);
            step(1, v, 1);
        end
        step(0, 0, 1);
        expect_frame(4, 1);
        wait_drain(0, 16, 60);
        cmp("post_reset", 0);
        check("post_reset drop_count", 32'(ifa.drop_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
